// File: rtl/mem_access_unit_pkg.sv
// Purpose: shared types, defaults and address helpers for the memory access unit.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package mem_access_unit_pkg;

  // Number of 32-bit words implemented by the default memory block.
  localparam int unsigned DEF_MEM_WORDS = 1024;

  // Access FSM encodings; these values are visible on the bus monitor.
  typedef enum logic [1:0] {
    MAB_IDLE   = 2'd0,
    MAB_ACCESS = 2'd1,
    MAB_RESP   = 2'd2
  } mab_state_t;

  // Word index of a byte address.
  function automatic logic [29:0] word_index(input logic [31:0] addr);
    return addr[31:2];
  endfunction

  // Misaligned or beyond the implemented words. Full 32-bit compare: no wrap.
  function automatic logic addr_fault(input logic [31:0] addr, input int unsigned mem_words);
    return (addr[1:0] != 2'b00) || ({2'b00, word_index(addr)} >= mem_words);
  endfunction

  // Counter width able to hold n, never narrower than one bit.
  function automatic int cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Purpose: control-side request/response and memory-side strobe/data bundle.
// Latency: n/a (wires only).
// Backpressure: requests are only taken while oBusy is low; no queueing.
interface mem_access_unit_if;
  logic        iReq;
  logic        iWe;
  logic [31:0] iAddr;
  logic [31:0] iWData;
  logic        oBusy;
  logic        oDone;
  logic        oFault;
  logic [31:0] oRData;
  logic        oMemRead;
  logic        oMemWrite;
  logic [31:0] oMemAddr;
  logic [31:0] oMemData;
  logic [31:0] iMemData;

  // The access unit is the bus initiator towards memory.
  modport master (
    input  iReq, iWe, iAddr, iWData, iMemData,
    output oBusy, oDone, oFault, oRData,
    output oMemRead, oMemWrite, oMemAddr, oMemData
  );

  // Control unit plus memory block, seen from the other side.
  modport slave (
    output iReq, iWe, iAddr, iWData, iMemData,
    input  oBusy, oDone, oFault, oRData,
    input  oMemRead, oMemWrite, oMemAddr, oMemData
  );
endinterface

// File: rtl/mem_access_unit_wait_counter.sv
// Purpose: loadable down-counter timing the strobe hold in the access phase.
// Latency: load/decrement take effect on the next edge; zero flag is registered-state decode.
// Backpressure: none; decrement saturates at zero.
module wait_counter
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 0,
  localparam int         WIDTH     = cnt_width(MAX_COUNT)
) (
  input  logic             iClk,
  input  logic             nRst,
  input  logic             iLoad,
  input  logic             iDec,
  input  logic [WIDTH-1:0] iValue,
  output logic             oZero
);

  logic [WIDTH-1:0] cnt;

  // Load has priority; otherwise count down towards zero and stay there.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      cnt <= '0;
    end else if (iLoad) begin
      cnt <= iValue;
    end else if (iDec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign oZero = (cnt == '0);

endmodule

// File: rtl/mem_access_unit.sv
// Purpose: single-outstanding load/store initiator driving the word-addressed memory bus.
// Latency: oDone at cycle WAIT_CYCLES+2 after acceptance, cycle 1 on a fault.
// Backpressure: oBusy high from the cycle after acceptance through RESP; iReq ignored meanwhile.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned MEM_WORDS   = DEF_MEM_WORDS
) (
  input  logic             iClk,
  input  logic             nRst,
  mem_access_unit_if.master bus
);

  localparam int            CW       = cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0] WAIT_VAL = CW'(WAIT_CYCLES);

  mab_state_t  state;
  logic        we_q;
  logic        fault_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] rdata_q;

  logic        req_fault;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_zero;

  // Request decode: only a clean request in IDLE arms the wait counter.
  always_comb begin
    req_fault = addr_fault(bus.iAddr, MEM_WORDS);
    cnt_load  = (state == MAB_IDLE) && bus.iReq && !req_fault;
    cnt_dec   = (state == MAB_ACCESS) && !cnt_zero;
  end

  wait_counter #(
    .MAX_COUNT (WAIT_CYCLES)
  ) u_wait (
    .iClk   (iClk),
    .nRst   (nRst),
    .iLoad  (cnt_load),
    .iDec   (cnt_dec),
    .iValue (WAIT_VAL),
    .oZero  (cnt_zero)
  );

  // Access FSM with request capture and the MDR; reset drops any strobe at once.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state   <= MAB_IDLE;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        MAB_IDLE: begin
          if (bus.iReq) begin
            addr_q <= bus.iAddr;
            data_q <= bus.iWData;
            we_q   <= bus.iWe;
            if (req_fault) begin
              fault_q <= 1'b1;
              state   <= MAB_RESP;
            end else begin
              state   <= MAB_ACCESS;
            end
          end
        end
        MAB_ACCESS: begin
          if (cnt_zero) begin
            if (!we_q) begin
              rdata_q <= bus.iMemData;
            end
            state <= MAB_RESP;
          end
        end
        MAB_RESP: begin
          fault_q <= 1'b0;
          state   <= MAB_IDLE;
        end
        default: begin
          state <= MAB_IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only; the write strobe fires in the last access cycle.
  assign bus.oBusy     = (state != MAB_IDLE);
  assign bus.oDone     = (state == MAB_RESP);
  assign bus.oFault    = (state == MAB_RESP) && fault_q;
  assign bus.oRData    = rdata_q;
  assign bus.oMemRead  = (state == MAB_ACCESS) && !we_q;
  assign bus.oMemWrite = (state == MAB_ACCESS) && we_q && cnt_zero;
  assign bus.oMemAddr  = addr_q;
  assign bus.oMemData  = data_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Processor-side initiator for the word-addressed memory bus (read strobe, write strobe, address, write data, read data).
- Accepts one load/store request at a time from the control unit and drives the memory strobes with registered address and data.
- Captures read data into an internal MDR register and reports completion or fault to the control unit.
- Sits between the control/datapath and the memory block.

Parameters:
- WAIT_CYCLES, 0: extra cycles the strobe is held before read data is sampled or the write strobe fires. 0 matches the combinational-read memory.
- MEM_WORDS, 1024: number of 32-bit words implemented. Word index at or above this raises a fault.

Ports:
- iClk  in  1  system clock, rising edge.
- nRst  in  1  asynchronous active-low reset.
- iReq  in  1  request from control; sampled only when oBusy=0.
- iWe  in  1  1=store, 0=load; sampled with iReq.
- iAddr  in  32  byte address; sampled with iReq.
- iWData  in  32  store data; sampled with iReq.
- oBusy  out  1  high from the cycle after acceptance through the RESP cycle.
- oDone  out  1  one-cycle completion pulse.
- oFault  out  1  valid with oDone: misaligned or out-of-range access.
- oRData  out  32  MDR; last successful load data, held until the next successful load.
- oMemRead  out  1  memory read strobe.
- oMemWrite  out  1  memory write strobe.
- oMemAddr  out  32  registered byte address to memory.
- oMemData  out  32  registered write data to memory.
- iMemData  in  32  read data from memory, combinational w.r.t. address and strobe.

Behaviour:
- Reset (async, nRst=0): state=IDLE; every output 0, including oRData and wait counter. Takes effect immediately, mid-access included; an in-progress strobe drops, and an unfired write never reaches memory.
- All outputs are registered or decoded from registered state only. No combinational path from iReq to the memory strobes.
- IDLE:
  - oBusy=0.
  - On edge with iReq=1: latch iWe, iAddr, iWData into oMemAddr/oMemData/we register.
  - Fault check on iAddr: fault if iAddr[1:0]!=0 or iAddr[31:2]>=MEM_WORDS.
  - Fault → go to RESP with fault flag set. No strobe is ever asserted.
  - No fault → go to ACCESS; wait counter loaded with WAIT_CYCLES.
- ACCESS:
  - oBusy=1.
  - Load: oMemRead=1 in every ACCESS cycle.
  - Store: oMemWrite=1 only in the final ACCESS cycle (counter==0), so memory sees exactly one write edge.
  - Counter!=0 → decrement, stay.
  - Counter==0 → on that edge, a load samples iMemData into oRData. Go to RESP.
  - ACCESS therefore lasts WAIT_CYCLES+1 cycles.
- RESP:
  - oBusy=1, oDone=1, oFault=fault flag; strobes 0.
  - Next edge → IDLE; fault flag cleared.
- Latency: acceptance edge at cycle 0; oDone at cycle WAIT_CYCLES+2 for a good access, cycle 1 for a fault.
- iReq while oBusy=1 is ignored, with no queueing. Control must re-assert after oDone.
- iReq held high continuously → a new request is accepted on the first IDLE edge after RESP.
- A store or a faulted load leaves oRData unchanged.
- oMemAddr/oMemData hold their last value in IDLE. Memory ignores them with strobes low.
- Address arithmetic: the fault check uses the full 32-bit iAddr. There is no wrap into the implemented range; e.g. 0x0000_1000 faults with MEM_WORDS=1024.

Decomposition:
- Shared header mem_bus.vh (alongside ISA.vh):
  - state encodings MAB_IDLE=2'd0, MAB_ACCESS=2'd1, MAB_RESP=2'd2;
  - default MEM_WORDS;
  - word-index macro (addr[31:2]).
- One sub-module: wait_counter. Loadable down-counter (load, value, zero flag), width $clog2(WAIT_CYCLES+1) with a minimum of 1, async active-low reset.
- The FSM and the MDR stay in mem_access_unit.

Test Plan:
- Reset: nRst=0 mid-sim → all outputs 0 immediately. Release, iReq=0 for 5 cycles → oBusy/oMemRead/oMemWrite stay 0.
- WAIT_CYCLES=0, store 0xDEADBEEF to 0x10, then load 0x10:
  - store: oMemWrite high exactly 1 cycle, oMemAddr=0x10, oDone at cycle 2;
  - load: oDone at cycle 2, oRData=0xDEADBEEF, oFault=0.
- WAIT_CYCLES=2, load 0x4 with memory word 1 preloaded 0x12345678 → oMemRead high for 3 cycles, oDone at cycle 4, oRData=0x12345678.
- Misaligned load of 0x6 and store to 0x0000_1000 (MEM_WORDS=1024):
  - each gives oDone+oFault at cycle 1;
  - no strobe asserted;
  - oRData keeps its previous value.
- iReq pulsed with addr 0x20 during ACCESS of a load to 0x8 → ignored; only the 0x8 access occurs and a single oDone is seen.
- nRst asserted in the first ACCESS cycle of a WAIT_CYCLES=2 store to 0xC → oMemWrite never asserted, memory word 3 unchanged, unit back in IDLE after release.
